denetim_birimi: RTL and testbench

- Multicycle fetch/decode/execute controller for the 8-bit CPU, sitting directly upstream of the ALU.
- Fetches 16-bit instructions over a req/valid handshake and holds a 4x8 register file.
- Drives the ALU operation code and both operands, then writes the ALU result back.
- Owns PC, zero flag and halt state.

---
 rtl/denetim_pkg.sv | 39 +++
 rtl/yazmac_obegi.sv | 32 +++
 rtl/denetim_birimi.sv | 142 ++++++++++++++
 tb/tb_denetim_birimi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/denetim_pkg.sv
// rtl/denetim_pkg.sv - shared states, instruction fields and ALU op codes for the controller
package denetim_pkg;

    typedef enum logic [2:0] {
        BOS   = 3'd0,
        GETIR = 3'd1,
        COZ   = 3'd2,
        YURUT = 3'd3,
        DUR   = 3'd4,
        BEKLE = 3'd5
    } durum_t;

    localparam logic [1:0] SINIF_ALU_REG = 2'b00;
    localparam logic [1:0] SINIF_ALU_IMM = 2'b01;
    localparam logic [1:0] SINIF_ATLA    = 2'b10;
    localparam logic [1:0] SINIF_DUR     = 2'b11;

    localparam int SINIF_MSB = 15;
    localparam int SINIF_LSB = 14;
    localparam int ISLEM_MSB = 13;
    localparam int ISLEM_LSB = 11;
    localparam int RD_LSB    = 9;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    localparam logic [2:0] TOPLA = 3'b000;
    localparam logic [2:0] CIKAR = 3'b001;
    localparam logic [2:0] ARTIR = 3'b010;
    localparam logic [2:0] AZALT = 3'b011;
    localparam logic [2:0] VE    = 3'b100;
    localparam logic [2:0] VEYA  = 3'b101;
    localparam logic [2:0] DEGIL = 3'b110;
    localparam logic [2:0] GECIR = 3'b111;

    function automatic logic alu_sinifi(input logic [1:0] sinif);
        return (sinif == SINIF_ALU_REG) || (sinif == SINIF_ALU_IMM);
    endfunction

endpackage

// File: rtl/yazmac_obegi.sv
// rtl/yazmac_obegi.sv - register file, two combinational reads and one synchronous write
module yazmac_obegi #(
    parameter int VERI_W   = 8,
    parameter int REG_SAYI = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(REG_SAYI)-1:0] oku_a_adr,
    output logic [VERI_W-1:0]           oku_a_veri,
    input  logic [$clog2(REG_SAYI)-1:0] oku_b_adr,
    output logic [VERI_W-1:0]           oku_b_veri,
    input  logic                        yaz_en,
    input  logic [$clog2(REG_SAYI)-1:0] yaz_adr,
    input  logic [VERI_W-1:0]           yaz_veri
);

    logic [VERI_W-1:0] yazmac [REG_SAYI];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_SAYI; i++) begin
                yazmac[i] <= '0;
            end
        end else if (yaz_en) begin
            yazmac[yaz_adr] <= yaz_veri;
        end
    end

    assign oku_a_veri = yazmac[oku_a_adr];
    assign oku_b_veri = yazmac[oku_b_adr];

endmodule

// File: rtl/denetim_birimi.sv
// rtl/denetim_birimi.sv - multicycle fetch/decode/execute controller; DENETIM_ADIM_EN adds single-step
module denetim_birimi
    import denetim_pkg::*;
#(
    parameter int VERI_W   = 8,
    parameter int PC_W     = 8,
    parameter int REG_SAYI = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
`ifdef DENETIM_ADIM_EN
    input  logic              adim_in,
`endif
    output logic              komut_istek_out,
    output logic [PC_W-1:0]   komut_adres_out,
    input  logic              komut_gecerli_in,
    input  logic [15:0]       komut_in,
    output logic [2:0]        islem_out,
    output logic [VERI_W-1:0] s1_out,
    output logic [VERI_W-1:0] s2_out,
    input  logic [VERI_W-1:0] sonuc_in,
    output logic              sifir_out,
    output logic              durdu_out
);

    localparam int RI_W = $clog2(REG_SAYI);

`ifdef DENETIM_ADIM_EN
    localparam durum_t DONUS = BEKLE;
`else
    localparam durum_t DONUS = GETIR;
`endif

    durum_t            durum, sonraki;
    logic [15:0]       komut;
    logic [PC_W-1:0]   pc;
    logic [1:0]        sinif;
    logic [2:0]        islem;
    logic [RI_W-1:0]   rd, rs;
    logic [7:0]        imm;
    logic [VERI_W-1:0] oku_a, oku_b;
    logic              yaz_en;
    logic              unused_ayrik;

    assign sinif        = komut[SINIF_MSB:SINIF_LSB];
    assign islem        = komut[ISLEM_MSB:ISLEM_LSB];
    assign rd           = komut[RD_LSB +: RI_W];
    assign rs           = komut[RI_W-1:0];
    assign imm          = komut[IMM_MSB:IMM_LSB];
    assign unused_ayrik = komut[8];

    assign komut_adres_out = pc;
    assign yaz_en          = (durum == YURUT) && alu_sinifi(sinif);

    yazmac_obegi #(
        .VERI_W   (VERI_W),
        .REG_SAYI (REG_SAYI)
    ) u_yazmac_obegi (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .oku_a_adr  (rd),
        .oku_a_veri (oku_a),
        .oku_b_adr  (rs),
        .oku_b_veri (oku_b),
        .yaz_en     (yaz_en),
        .yaz_adr    (rd),
        .yaz_veri   (sonuc_in)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            durum <= BOS;
        end else begin
            durum <= sonraki;
        end
    end

    always_comb begin
        sonraki         = durum;
        komut_istek_out = 1'b0;
        durdu_out       = 1'b0;
        case (durum)
            BOS:   sonraki = DONUS;
            GETIR: begin
                komut_istek_out = 1'b1;
                if (komut_gecerli_in) begin
                    sonraki = COZ;
                end
            end
            COZ:   sonraki = (sinif == SINIF_DUR) ? DUR : YURUT;
            YURUT: sonraki = DONUS;
            DUR:   durdu_out = 1'b1;
`ifdef DENETIM_ADIM_EN
            BEKLE: begin
                if (adim_in) begin
                    sonraki = GETIR;
                end
            end
`endif
            default: sonraki = BOS;
        endcase
    end

    // PC advances at fetch, so a jump target in YURUT overrides the sequential value
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc        <= '0;
            komut     <= '0;
            islem_out <= '0;
            s1_out    <= '0;
            s2_out    <= '0;
            sifir_out <= 1'b0;
        end else begin
            case (durum)
                GETIR: begin
                    if (komut_gecerli_in) begin
                        komut <= komut_in;
                        pc    <= pc + PC_W'(1);
                    end
                end
                COZ: begin
                    if (alu_sinifi(sinif)) begin
                        islem_out <= islem;
                        s1_out    <= oku_a;
                        s2_out    <= (sinif == SINIF_ALU_REG) ? oku_b : VERI_W'(imm);
                    end
                end
                YURUT: begin
                    if (alu_sinifi(sinif)) begin
                        sifir_out <= (sonuc_in == '0);
                    end else if (sinif == SINIF_ATLA) begin
                        if (!islem[0] || sifir_out) begin
                            pc <= PC_W'(imm);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_denetim_birimi.sv
// tb/tb_denetim_birimi.sv - scoreboard bench: expected state at each instruction fetch
module tb_denetim_birimi;
    import denetim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        istek, gecerli, sifir, durdu;
    logic [7:0]  adres, s1, s2, sonuc;
    logic [15:0] komut;
    logic [2:0]  islem;
    logic [15:0] mem [256];

`ifdef DENETIM_ADIM_EN
    logic adim = 1'b1;
    localparam int ADIM_EK = 1;
`else
    localparam int ADIM_EK = 0;
`endif

    typedef struct {
        logic [7:0] adres;
        logic       sifir;
        logic [2:0] islem;
        logic [7:0] s1;
        logic [7:0] s2;
        int         gap;
    } bek_t;

    bek_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    denetim_birimi dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
`ifdef DENETIM_ADIM_EN
        .adim_in          (adim),
`endif
        .komut_istek_out  (istek),
        .komut_adres_out  (adres),
        .komut_gecerli_in (gecerli),
        .komut_in         (komut),
        .islem_out        (islem),
        .s1_out           (s1),
        .s2_out           (s2),
        .sonuc_in         (sonuc),
        .sifir_out        (sifir),
        .durdu_out        (durdu)
    );

    assign komut = mem[adres];

    always_comb begin
        sonuc = 8'h00;
        case (islem)
            TOPLA: sonuc = s1 + s2;
            CIKAR: sonuc = s1 - s2;
            ARTIR: sonuc = s1 + 8'h01;
            AZALT: sonuc = s1 - 8'h01;
            VE:    sonuc = s1 & s2;
            VEYA:  sonuc = s1 | s2;
            DEGIL: sonuc = ~s1;
            GECIR: sonuc = s2;
            default: sonuc = 8'h00;
        endcase
    end

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
        end
    endtask

    task automatic bekle_ekle(input logic [7:0] a, input logic z, input logic [2:0] op,
                              input logic [7:0] v1, input logic [7:0] v2, input int g);
        bek_t b;
        b.adres = a; b.sifir = z; b.islem = op; b.s1 = v1; b.s2 = v2; b.gap = g;
        sb.push_back(b);
    endtask

    task automatic wait_accept(input logic [7:0] a);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rst_n && istek && gecerli && adres == a) ok = 1'b1;
        end
        kontrol("accept_timeout", 32'(ok), 32'd1);
    endtask

    // monitor: every accepted fetch shows the state left by the previous instruction
    initial begin
        int   cyc = 0;
        int   son = -1;
        bek_t b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                son = -1;
            end else if (istek && gecerli) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: unexpected fetch at adres %0h", adres);
                end else begin
                    b = sb.pop_front();
                    kontrol("adres", 32'(adres), 32'(b.adres));
                    kontrol("sifir", 32'(sifir), 32'(b.sifir));
                    kontrol("islem", 32'(islem), 32'(b.islem));
                    kontrol("s1",    32'(s1),    32'(b.s1));
                    kontrol("s2",    32'(s2),    32'(b.s2));
                    if (b.gap >= 0) kontrol("gap", 32'(cyc - son), 32'(b.gap + ADIM_EK));
                end
                son = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gordu;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
        mem[8'h00] = 16'h7A2A;  // GECIR R1, 0x2A
        mem[8'h01] = 16'h0201;  // TOPLA R1, R1
        mem[8'h02] = 16'h2A01;  // VEYA  R1, R1
        mem[8'h03] = 16'h7801;  // GECIR R0, 0x01
        mem[8'h04] = 16'h1800;  // AZALT R0
        mem[8'h05] = 16'h8810;  // JZ 0x10
        mem[8'h10] = 16'h7C07;  // GECIR R2, 0x07
        mem[8'h11] = 16'h8830;  // JZ 0x30, not taken
        mem[8'h12] = 16'h80FF;  // JMP 0xFF
        mem[8'hFF] = 16'h5600;  // ARTIR R3, then PC wraps
        gecerli = 1'b1;
        rst_n   = 1'b0;

        bekle_ekle(8'h00, 1'b0, 3'd0, 8'h00, 8'h00, -1);
        bekle_ekle(8'h01, 1'b0, GECIR, 8'h00, 8'h2A, 3);
        bekle_ekle(8'h02, 1'b0, TOPLA, 8'h2A, 8'h2A, 3);
        bekle_ekle(8'h03, 1'b0, VEYA,  8'h54, 8'h54, 3);
        bekle_ekle(8'h04, 1'b0, GECIR, 8'h00, 8'h01, 3);
        bekle_ekle(8'h05, 1'b1, AZALT, 8'h01, 8'h01, 3);
        bekle_ekle(8'h10, 1'b1, AZALT, 8'h01, 8'h01, 3);
        bekle_ekle(8'h11, 1'b0, GECIR, 8'h00, 8'h07, 3);
        bekle_ekle(8'h12, 1'b0, GECIR, 8'h00, 8'h07, 3);
        bekle_ekle(8'hFF, 1'b0, GECIR, 8'h00, 8'h07, 3);
        bekle_ekle(8'h00, 1'b0, ARTIR, 8'h00, 8'h00, 6);
        bekle_ekle(8'h40, 1'b0, ARTIR, 8'h00, 8'h00, 3);

        repeat (2) @(negedge clk);
        #1;
        kontrol("rst_istek", 32'(istek), 32'd0);
        kontrol("rst_adres", 32'(adres), 32'd0);
        kontrol("rst_durdu", 32'(durdu), 32'd0);
        kontrol("rst_sifir", 32'(sifir), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        kontrol("bos_istek", 32'(istek), 32'd0);
        @(negedge clk);
        kontrol("getir_istek", 32'(istek), 32'(ADIM_EK == 0));

        // hold fetch valid low for three request cycles at the wrapped PC
        wait_accept(8'hFF);
        @(posedge clk);
        #1;
        gecerli    = 1'b0;
        mem[8'h00] = 16'h8040;  // JMP 0x40
        gordu      = 1'b0;
        for (int i = 0; i < 20 && !gordu; i++) begin
            @(negedge clk);
            if (istek) gordu = 1'b1;
        end
        kontrol("istek_gorulmedi", 32'(gordu), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            kontrol("bekle_istek", 32'(istek), 32'd1);
            kontrol("bekle_adres", 32'(adres), 32'd0);
        end
        @(posedge clk);
        #1;
        gecerli = 1'b1;

        wait_accept(8'h40);
        gordu = 1'b0;
        for (int i = 0; i < 10 && !gordu; i++) begin
            @(negedge clk);
            if (durdu) gordu = 1'b1;
        end
        kontrol("durdu_gorulmedi", 32'(gordu), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            kontrol("dur_durdu", 32'(durdu), 32'd1);
            kontrol("dur_istek", 32'(istek), 32'd0);
        end
        kontrol("sb_bos_1", 32'(sb.size()), 32'd0);

        // reset in the middle of an instruction
        rst_n      = 1'b0;
        mem[8'h00] = 16'h7A2A;
        bekle_ekle(8'h00, 1'b0, 3'd0, 8'h00, 8'h00, -1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_accept(8'h00);
        repeat (2) @(negedge clk);
        kontrol("yurut_s2", 32'(s2), 32'h2A);
        rst_n = 1'b0;
        #1;
        kontrol("ara_rst_istek", 32'(istek), 32'd0);
        kontrol("ara_rst_adres", 32'(adres), 32'd0);
        kontrol("ara_rst_islem", 32'(islem), 32'd0);
        kontrol("ara_rst_s1",    32'(s1),    32'd0);
        kontrol("ara_rst_s2",    32'(s2),    32'd0);
        kontrol("ara_rst_sifir", 32'(sifir), 32'd0);
        kontrol("ara_rst_durdu", 32'(durdu), 32'd0);
        mem[8'h00] = 16'h0201;  // TOPLA R1, R1 must read the cleared R1
        bekle_ekle(8'h00, 1'b0, 3'd0, 8'h00, 8'h00, -1);
        bekle_ekle(8'h01, 1'b1, TOPLA, 8'h00, 8'h00, 3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_accept(8'h01);
        @(posedge clk);
        #1;
        gecerli = 1'b0;
        repeat (5) @(negedge clk);
        kontrol("sb_bos_2", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
